// File: rtl/xpb_accum_ctrl.sv
// -----------------------------------------------------------------------------
// xpb_accum_ctrl
//
// Sequencing controller for the shared xpb precomputed-multiple lookup tables
// in the modular-squaring reduction path. It accepts a vector of DIGIT_W-bit
// digits and issues one table lookup per cycle, in ascending digit index, to a
// single external xpb table bank. It accumulates the returned WORD_W-bit
// multiples into one wide sum and presents that sum to the downstream
// reduction adder with a valid/ack handshake.
//
// Optional feature macro: XPB_ZERO_SKIP_EN
//   defined   : zero digits are not issued. A priority encoder jumps to the
//               next nonzero digit. An all-zero vector goes straight to DONE
//               with result = 0.
//   undefined : every digit is issued, including zeros.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   begin an operation (honoured only while ready)
//   digits_in    in   NUM_DIGITS*DIGIT_W; digit i at [i*DIGIT_W +: DIGIT_W]
//   ready        out  controller idle, start will be accepted
//   lut_req      out  a lookup is issued this cycle
//   lut_sel      out  table segment index (0 when lut_req = 0)
//   lut_digit    out  table address / digit value (0 when lut_req = 0)
//   lut_data     in   table output, valid LUT_LAT cycles after lut_req
//   result       out  accumulated sum, WORD_W+ACC_EXT bits
//   result_valid out  result valid, held until result_ack
//   result_ack   in   consumer takes the result
// -----------------------------------------------------------------------------
module xpb_accum_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int DIGIT_W    = 5,
    parameter int WORD_W     = 1024,
    parameter int ACC_EXT    = 4,
    parameter int LUT_LAT    = 1,
    // Derived; not intended to be overridden.
    parameter int SEL_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
    output logic                          ready,
    output logic                          lut_req,
    output logic [SEL_W-1:0]              lut_sel,
    output logic [DIGIT_W-1:0]            lut_digit,
    input  logic [WORD_W-1:0]             lut_data,
    output logic [WORD_W+ACC_EXT-1:0]     result,
    output logic                          result_valid,
    input  logic                          result_ack
);

    localparam int ACC_W = WORD_W + ACC_EXT;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                          state_reg, state_next;
    logic [NUM_DIGITS*DIGIT_W-1:0]   digits_reg;
    // One bit per digit that still has to be issued in this operation.
    logic [NUM_DIGITS-1:0]           pend_reg, pend_next;
    logic [NUM_DIGITS-1:0]           pend_after;
    logic [NUM_DIGITS-1:0]           start_mask;
    logic [ACC_W-1:0]                acc_reg;
    logic [SEL_W-1:0]                cur_idx;
    logic                            issue;
    logic                            data_valid;  // lut_data carries a requested entry
    logic                            in_flight;   // lookups that return after this cycle

    // ---------------------------------------------------------------- digit mask
`ifdef XPB_ZERO_SKIP_EN
    logic [NUM_DIGITS-1:0] nz_mask;
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nz
        assign nz_mask[gi] = |digits_in[gi*DIGIT_W +: DIGIT_W];
    end
    assign start_mask = nz_mask;
`else
    assign start_mask = {NUM_DIGITS{1'b1}};
`endif

    // Lowest pending index wins, so digits go out in ascending order.
    always_comb begin
        cur_idx = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (pend_reg[i]) begin
                cur_idx = SEL_W'(i);
            end
        end
    end

    assign issue      = (state_reg == S_ISSUE);
    assign pend_after = pend_reg & ~(NUM_DIGITS'(1) << cur_idx);

    // ---------------------------------------------------------- valid pipeline
    if (LUT_LAT == 0) begin : g_comb_lut
        assign data_valid = issue;
        assign in_flight  = 1'b0;
    end else begin : g_pipe_lut
        logic [LUT_LAT-1:0] vpipe_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vpipe_reg <= '0;
            end else begin
                vpipe_reg <= (vpipe_reg << 1) | LUT_LAT'(issue);
            end
        end

        assign data_valid = vpipe_reg[LUT_LAT-1];
        // Everything below the output stage is still on its way back.
        assign in_flight  = |(vpipe_reg & ~(LUT_LAT'(1) << (LUT_LAT - 1)));
    end

    // ---------------------------------------------------------------- FSM
    always_comb begin
        state_next = state_reg;
        pend_next  = pend_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    pend_next = start_mask;
`ifdef XPB_ZERO_SKIP_EN
                    if (start_mask == '0) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_ISSUE;
                    end
`else
                    state_next = S_ISSUE;
`endif
                end
            end
            S_ISSUE: begin
                pend_next = pend_after;
                if (pend_after == '0) begin
                    // A combinational table has nothing left to wait for.
                    if (LUT_LAT == 0) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!in_flight) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (result_ack) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            pend_reg   <= '0;
            digits_reg <= '0;
            acc_reg    <= '0;
        end else begin
            state_reg <= state_next;
            pend_reg  <= pend_next;
            if (state_reg == S_IDLE && start) begin
                digits_reg <= digits_in;
                acc_reg    <= '0;
            end else if (data_valid) begin
                acc_reg <= acc_reg + ACC_W'(lut_data);
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    assign ready        = (state_reg == S_IDLE);
    assign lut_req      = issue;
    assign lut_sel      = issue ? cur_idx : '0;
    assign lut_digit    = issue ? digits_reg[cur_idx*DIGIT_W +: DIGIT_W] : '0;
    assign result       = acc_reg;
    assign result_valid = (state_reg == S_DONE);

endmodule

// File: tb/tb_xpb_accum_ctrl.sv
// -----------------------------------------------------------------------------
// tb_xpb_accum_ctrl
//
// Directed bench for xpb_accum_ctrl with NUM_DIGITS=8, LUT_LAT=1, WORD_W=1024.
// The table model returns lut_digit*(lut_sel+1), registered for one cycle, or
// all-ones while ovf_mode is set. Inputs are driven on the falling edge and
// outputs are sampled on the falling edge. Cycle 0 is the cycle whose closing
// rising edge accepts start.
// -----------------------------------------------------------------------------
module tb_xpb_accum_ctrl;

    localparam int ND  = 8;
    localparam int DW  = 5;
    localparam int WW  = 1024;
    localparam int AE  = 4;
    localparam int LAT = 1;
    localparam int AW  = WW + AE;

`ifdef XPB_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ND*DW-1:0]  digits_in = '0;
    logic              ready;
    logic              lut_req;
    logic [2:0]        lut_sel;
    logic [DW-1:0]     lut_digit;
    logic [WW-1:0]     lut_data = '0;
    logic [AW-1:0]     result;
    logic              result_valid;
    logic              result_ack = 1'b0;
    logic              ovf_mode = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    xpb_accum_ctrl #(
        .NUM_DIGITS (ND),
        .DIGIT_W    (DW),
        .WORD_W     (WW),
        .ACC_EXT    (AE),
        .LUT_LAT    (LAT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .digits_in    (digits_in),
        .ready        (ready),
        .lut_req      (lut_req),
        .lut_sel      (lut_sel),
        .lut_digit    (lut_digit),
        .lut_data     (lut_data),
        .result       (result),
        .result_valid (result_valid),
        .result_ack   (result_ack)
    );

    // One-cycle table model.
    always @(posedge clk) begin
        if (ovf_mode) begin
            lut_data <= {WW{1'b1}};
        end else begin
            lut_data <= WW'(lut_digit) * (WW'(lut_sel) + WW'(1));
        end
    end

    task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h..%h exp=%h..%h", tag,
                     got[AW-1:AW-68], got[63:0], exp[AW-1:AW-68], exp[63:0]);
        end
    endtask

    // Runs one operation from a falling edge; returns at the falling edge of
    // the first cycle with result_valid high (or after the cycle budget).
    task automatic run_op(input logic [ND*DW-1:0] d, input logic [AW-1:0] exp_res,
                          input int exp_vcyc);
        int exp_sel[$];
        int cyc;
        int reqs;
        int vcyc;
        for (int i = 0; i < ND; i++) begin
            if (!SKIP || d[i*DW +: DW] != '0) exp_sel.push_back(i);
        end
        check("ready_before_start", AW'(ready), AW'(1));
        digits_in = d;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        digits_in = ~d;
        cyc  = 1;
        reqs = 0;
        vcyc = -1;
        while (vcyc < 0 && cyc < 40) begin
            @(negedge clk);
            if (lut_req) begin
                if (reqs < exp_sel.size()) begin
                    check("lut_sel", AW'(lut_sel), AW'(exp_sel[reqs]));
                    check("lut_digit", AW'(lut_digit), AW'(d[exp_sel[reqs]*DW +: DW]));
                    check("req_cycle", AW'(cyc), AW'(reqs + 1));
                end else begin
                    check("req_over", AW'(reqs + 1), AW'(exp_sel.size()));
                end
                reqs++;
            end else begin
                check("sel_idle", AW'(lut_sel), AW'(0));
                check("digit_idle", AW'(lut_digit), AW'(0));
            end
            if (result_valid) begin
                vcyc = cyc;
            end else begin
                @(posedge clk);
                cyc++;
            end
        end
        check("valid_cycle", AW'(vcyc), AW'(exp_vcyc));
        check("result", result, exp_res);
        check("req_count", AW'(reqs), AW'(exp_sel.size()));
        $display("op digits=%h reqs=%0d valid_cycle=%0d result_low=%h",
                 d, reqs, vcyc, result[63:0]);
    endtask

    // Ack in cycle t, expect ready in cycle t+1; returns at that falling edge.
    task automatic do_ack();
        result_ack = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_ack = 1'b0;
        check("ready_after_ack", AW'(ready), AW'(1));
        check("valid_after_ack", AW'(result_valid), AW'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, AW'(ready), AW'(1));
        check({tag, "_req"}, AW'(lut_req), AW'(0));
        check({tag, "_sel"}, AW'(lut_sel), AW'(0));
        check({tag, "_digit"}, AW'(lut_digit), AW'(0));
        check({tag, "_result"}, result, AW'(0));
        check({tag, "_valid"}, AW'(result_valid), AW'(0));
    endtask

    initial begin
        logic [ND*DW-1:0] ramp;      // digit i = i+1, expected sum 204
        logic [AW-1:0]    exp_ovf;
        for (int i = 0; i < ND; i++) ramp[i*DW +: DW] = DW'(i + 1);
        exp_ovf = {4'h7, {255{4'hF}}, 4'h8};

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // 1. All digits 0x1f: 31*(1+..+8) = 1116
        run_op({ND{5'h1f}}, AW'(12'h45C), 10);
        do_ack();

        // 2. All zeros
        run_op('0, '0, SKIP ? 1 : 10);
        do_ack();

        // 3. Only d3 = 5: 5*4 = 20
        run_op(40'h28000, AW'(20), SKIP ? 3 : 10);
        do_ack();

        // Ramp pattern: sum (i+1)^2 = 204
        run_op(ramp, AW'(204), 10);
        do_ack();

        // 4. Overflow into the extension bits
        ovf_mode = 1'b1;
        run_op(ramp, exp_ovf, 10);
        do_ack();
        ovf_mode = 1'b0;

        // 5. Backpressure with an ignored start
        run_op({ND{5'h1f}}, AW'(12'h45C), 10);
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                digits_in = ramp;
                start     = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            check("bp_result", result, AW'(12'h45C));
            check("bp_valid", AW'(result_valid), AW'(1));
            check("bp_ready", AW'(ready), AW'(0));
        end
        do_ack();
        run_op(ramp, AW'(204), 10);
        do_ack();

        // 6. Reset in cycle 4 of an all-0x1f operation
        digits_in = {ND{5'h1f}};
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_req", AW'(lut_req), AW'(1));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midop_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(ramp, AW'(204), 10);
        do_ack();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
